// File: rtl/data_sram_bridge.sv
// data_sram_bridge: request/response bridge from the load/store stage to the data SRAM.
// Issues one access at a time. It builds byte enables and replicated write data for
// stores, and extracts plus sign/zero-extends load data after RD_LAT cycles. Misaligned
// accesses never reach the SRAM; they complete with adel (load) or ades (store).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/wr/size/signed/addr/wdata  CPU request; req_ready accepts, stall = valid & ~ready
//   rsp_valid/rsp_rdata/adel/ades one-cycle completion with load data or address error
//   data_sram_en/wen/addr/wdata   SRAM strobe, driven only in the accept cycle
//   data_sram_rdata               SRAM read data, captured RD_LAT cycles after the strobe
module data_sram_bridge #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  adel,
  output logic                  ades,
  output logic                  data_sram_en,
  output logic [DATA_W/8-1:0]   data_sram_wen,
  output logic [ADDR_W-1:0]     data_sram_addr,
  output logic [DATA_W-1:0]     data_sram_wdata,
  input  logic [DATA_W-1:0]     data_sram_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, RWAIT, RESP} state_t;

  state_t              r_state;
  logic [LANE_W-1:0]   r_lane;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_adel;
  logic                r_ades;

  logic                w_ready;
  logic                w_accept;
  logic                w_misalign;
  logic                w_issue;
  logic [LANE_W-1:0]   w_lane;
  logic [STRB_W-1:0]   w_mask;
  logic [STRB_W-1:0]   w_wen;
  logic [DATA_W-1:0]   w_rep;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_load;

  assign w_ready  = (r_state == IDLE);
  assign w_accept = req_valid & w_ready & ~rst;
  assign w_lane   = req_addr[LANE_W-1:0];
  assign w_issue  = w_accept & ~w_misalign;

  // Alignment check; a dword on a 32-bit SRAM can never be aligned.
  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = |req_addr[1:0];
      default: w_misalign = (DATA_W == 32) ? 1'b1 : |req_addr[2:0];
    endcase
  end

  // Size mask and right-aligned store data replicated across every lane.
  always_comb begin
    w_mask = '0;
    w_rep  = '0;
    case (req_size)
      2'b00: begin
        w_mask = STRB_W'(8'h01);
        w_rep  = {STRB_W{req_wdata[7:0]}};
      end
      2'b01: begin
        w_mask = STRB_W'(8'h03);
        w_rep  = {(STRB_W/2){req_wdata[15:0]}};
      end
      2'b10: begin
        w_mask = STRB_W'(8'h0F);
        w_rep  = {(DATA_W/32){req_wdata[31:0]}};
      end
      default: begin
        w_mask = STRB_W'(8'hFF);
        w_rep  = req_wdata;
      end
    endcase
  end

  assign w_wen = w_mask << w_lane;

  // SRAM strobe is combinational from the request, only in the accept cycle.
  assign data_sram_en    = w_issue;
  assign data_sram_wen   = (w_issue & req_wr) ? w_wen : '0;
  assign data_sram_addr  = w_issue ? {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign data_sram_wdata = (w_issue & req_wr) ? w_rep : '0;

  // Select the addressed field of the read word and extend it.
  assign w_shifted = data_sram_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load = '0;
    case (r_size)
      2'b00: begin
        if (r_signed) w_load = DATA_W'($signed(w_shifted[7:0]));
        else          w_load = DATA_W'(w_shifted[7:0]);
      end
      2'b01: begin
        if (r_signed) w_load = DATA_W'($signed(w_shifted[15:0]));
        else          w_load = DATA_W'(w_shifted[15:0]);
      end
      2'b10: begin
        if (r_signed) w_load = DATA_W'($signed(w_shifted[31:0]));
        else          w_load = DATA_W'(w_shifted[31:0]);
      end
      default: w_load = w_shifted;
    endcase
  end

  // Access FSM; the response registers hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lane      <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_adel      <= 1'b0;
      r_ades      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lane   <= w_lane;
            r_size   <= req_size;
            r_signed <= req_signed;
            if (w_misalign || req_wr) begin
              r_adel      <= w_misalign & ~req_wr;
              r_ades      <= w_misalign & req_wr;
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_cnt   <= CNT_W'(RD_LAT);
              r_state <= RWAIT;
            end
          end
        end
        RWAIT: begin
          // r_cnt reaches 1 in the cycle the SRAM presents read data.
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_rdata <= w_load;
            r_adel      <= 1'b0;
            r_ades      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign stall     = req_valid & ~w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign adel      = r_adel;
  assign ades      = r_ades;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Expected SRAM strobes and responses are queued at accept time and popped by monitors.
module tb_data_sram_bridge;

  typedef struct packed {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] cyc;
  } rsp_t;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wd;
    logic [31:0] cyc;
  } sram_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_wr     [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        stall      [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        adel       [2];
  logic        ades       [2];
  logic        sram_en    [2];
  logic [3:0]  sram_wen   [2];
  logic [31:0] sram_addr  [2];
  logic [31:0] sram_wdata [2];
  logic [31:0] sram_rdata [2];

  rsp_t  rsp_q  [2][$];
  sram_t sram_q [2][$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h12F4_5678;
      32'h0000_0000: mem_word = 32'hCAFE_F00D;
      32'h0000_0004: mem_word = 32'h8000_0001;
      default:       mem_word = 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0h want %0h", nm, d, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    data_sram_bridge #(.DATA_W(32), .ADDR_W(32), .RD_LAT(LAT)) u_dut (
      .clk             (clk),
      .rst             (rst[g]),
      .req_valid       (req_valid[g]),
      .req_wr          (req_wr[g]),
      .req_size        (req_size[g]),
      .req_signed      (req_signed[g]),
      .req_addr        (req_addr[g]),
      .req_wdata       (req_wdata[g]),
      .req_ready       (req_ready[g]),
      .stall           (stall[g]),
      .rsp_valid       (rsp_valid[g]),
      .rsp_rdata       (rsp_rdata[g]),
      .adel            (adel[g]),
      .ades            (ades[g]),
      .data_sram_en    (sram_en[g]),
      .data_sram_wen   (sram_wen[g]),
      .data_sram_addr  (sram_addr[g]),
      .data_sram_wdata (sram_wdata[g]),
      .data_sram_rdata (sram_rdata[g])
    );

    // SRAM model: read data appears exactly LAT cycles after a read strobe, junk otherwise.
    logic [4:1]  vp = '0;
    logic [31:0] ap [1:4];
    always @(posedge clk) begin
      vp    <= {vp[3:1], sram_en[g] & (sram_wen[g] == 4'h0)};
      ap[1] <= sram_addr[g];
      ap[2] <= ap[1];
      ap[3] <= ap[2];
      ap[4] <= ap[3];
    end
    assign sram_rdata[g] = vp[LAT] ? mem_word(ap[LAT]) : 32'hBAD0_BAD0;

    rsp_t  e_rsp;
    sram_t e_sram;

    // Response monitor.
    always @(negedge clk) begin
      if (rsp_valid[g]) begin
        if (rsp_q[g].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected dut%0d cycle %0d: got rsp_valid=1 want 0", g, cyc);
        end else begin
          e_rsp = rsp_q[g].pop_front();
          chk("rsp_rdata", g, 64'(rsp_rdata[g]), 64'(e_rsp.rdata));
          chk("rsp_adel",  g, 64'(adel[g]),      64'(e_rsp.adel));
          chk("rsp_ades",  g, 64'(ades[g]),      64'(e_rsp.ades));
          chk("rsp_cycle", g, 64'(cyc),          64'(e_rsp.cyc));
        end
      end
    end

    // SRAM strobe monitor.
    always @(negedge clk) begin
      if (sram_en[g]) begin
        if (sram_q[g].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sram_unexpected dut%0d cycle %0d: got en=1 addr %0h want no strobe", g, cyc, sram_addr[g]);
        end else begin
          e_sram = sram_q[g].pop_front();
          chk("sram_wen",   g, 64'(sram_wen[g]),  64'(e_sram.wen));
          chk("sram_addr",  g, 64'(sram_addr[g]), 64'(e_sram.addr));
          chk("sram_cycle", g, 64'(cyc),          64'(e_sram.cyc));
          if (e_sram.chk_wd) chk("sram_wdata", g, 64'(sram_wdata[g]), 64'(e_sram.wdata));
        end
      end
    end
  end

  // Drive a request (valid left asserted) and queue its expectations at the accept cycle.
  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ex_sram, input logic [3:0] ex_wen, input logic [31:0] ex_saddr,
                       input logic [31:0] ex_wdata, input logic ex_rsp, input logic [31:0] ex_rdata,
                       input logic ex_adel, input logic ex_ades, input int lat,
                       output int acc, output int nst);
    sram_t s;
    rsp_t  r;
    req_wr[d]     = wr;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    acc = -1;
    nst = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready[d]) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
      if (stall[d]) nst++;
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: got no req_ready within 40 cycles want accept", d);
      return;
    end
    if (ex_sram) begin
      s.wen = ex_wen; s.addr = ex_saddr; s.wdata = ex_wdata; s.chk_wd = wr; s.cyc = 32'(acc);
      sram_q[d].push_back(s);
    end
    if (ex_rsp) begin
      r.rdata = ex_rdata; r.adel = ex_adel; r.ades = ex_ades; r.cyc = 32'(acc + lat);
      rsp_q[d].push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic st(input int d, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] ex_wen, input logic [31:0] ex_saddr, input logic [31:0] ex_wd);
    int a, n;
    issue(d, 1'b1, sz, 1'b0, addr, wd, 1'b1, ex_wen, ex_saddr, ex_wd, 1'b1, 32'h0, 1'b0, 1'b0, 1, a, n);
  endtask

  task automatic ld(input int d, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                    input logic [31:0] ex_saddr, input logic [31:0] ex_rd, input int lat);
    int a, n;
    issue(d, 1'b0, sz, sg, addr, 32'h5555_5555, 1'b1, 4'h0, ex_saddr, 32'h0, 1'b1, ex_rd, 1'b0, 1'b0, lat, a, n);
  endtask

  task automatic er(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] addr);
    int a, n;
    issue(d, wr, sz, 1'b0, addr, 32'h0000_1234, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, ~wr, wr, 1, a, n);
  endtask

  int acc1, acc2, nst1, nst2;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", d, 64'(req_ready[d]), 64'd1);
      chk("reset_rsp_valid", d, 64'(rsp_valid[d]), 64'd0);
      chk("reset_rdata", d, 64'(rsp_rdata[d]), 64'd0);
      chk("reset_adel", d, 64'(adel[d]), 64'd0);
      chk("reset_ades", d, 64'(ades[d]), 64'd0);
      chk("reset_en", d, 64'(sram_en[d]), 64'd0);
      chk("reset_wen", d, 64'(sram_wen[d]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // RD_LAT=1 instance: loads, stores, address errors.
    ld(0, 2'b10, 1'b0, 32'h100, 32'h100, 32'h12F4_5678, 2);
    ld(0, 2'b00, 1'b1, 32'h102, 32'h100, 32'hFFFF_FFF4, 2);
    ld(0, 2'b00, 1'b0, 32'h102, 32'h100, 32'h0000_00F4, 2);
    ld(0, 2'b01, 1'b1, 32'h102, 32'h100, 32'h0000_12F4, 2);
    ld(0, 2'b01, 1'b0, 32'h100, 32'h100, 32'h0000_5678, 2);
    er(0, 1'b0, 2'b10, 32'h102);
    st(0, 2'b10, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h100, 32'hDEAD_BEEF);
    st(0, 2'b00, 32'h103, 32'h0000_00AA, 4'b1000, 32'h100, 32'hAAAA_AAAA);
    st(0, 2'b01, 32'h102, 32'h0000_1234, 4'b1100, 32'h100, 32'h1234_1234);
    ld(0, 2'b00, 1'b1, 32'h101, 32'h100, 32'h0000_0056, 2);
    er(0, 1'b1, 2'b01, 32'h101);
    er(0, 1'b0, 2'b11, 32'h100);
    req_valid[0] = 1'b0;

    // RD_LAT=3 instance: back-to-back loads with valid held.
    issue(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0,
          1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 4, acc1, nst1);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0,
          1'b1, 32'h8000_0001, 1'b0, 1'b0, 4, acc2, nst2);
    req_valid[1] = 1'b0;
    chk("b2b_accept_gap", 1, 64'(acc2 - acc1), 64'd5);
    chk("b2b_stall_cycles", 1, 64'(nst2), 64'd4);
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of a load: the response must never appear.
    issue(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0,
          1'b0, 32'h0, 1'b0, 1'b0, 4, acc1, nst1);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 1, 64'(req_ready[1]), 64'd1);
    chk("rst_mid_rsp_valid", 1, 64'(rsp_valid[1]), 64'd0);
    chk("rst_mid_rdata", 1, 64'(rsp_rdata[1]), 64'd0);
    chk("rst_mid_en", 1, 64'(sram_en[1]), 64'd0);
    repeat (6) @(posedge clk);
    #1;

    // Request presented during reset is not accepted.
    rst[1] = 1'b1;
    req_wr[1] = 1'b1; req_size[1] = 2'b10; req_addr[1] = 32'h100; req_wdata[1] = 32'h0BAD_0BAD;
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("rst_req_en", 1, 64'(sram_en[1]), 64'd0);
    chk("rst_req_wen", 1, 64'(sram_wen[1]), 64'd0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    ld(1, 2'b01, 1'b1, 32'h100, 32'h100, 32'h0000_5678, 4);
    req_valid[1] = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rsp_queue_drained", d, 64'(rsp_q[d].size()), 64'd0);
      chk("sram_queue_drained", d, 64'(sram_q[d].size()), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 want finish");
    $fatal(1, "timeout");
  end

endmodule
